bias_add_3: RTL and testbench

Consumer for the layer-3 bias coefficient stream. At the start of each frame it drains N_CH bias words from the bias FIFO into a local register bank. It then adds the per-channel bias to every accumulator word of the conv-3 data stream, rescales and saturates the result, and emits it on an output FIFO. It sits between the conv-3 MAC array and the layer-3 activation stage.

---
 rtl/bias_add_3.sv | 127 ++++++++++++
 tb/tb_bias_add_3.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_add_3.sv
// Layer-3 bias stage: loads N_CH per-frame biases, then adds them to the conv-3
// accumulator stream, rescales by SHIFT and saturates to OUT_W.
module bias_add_3 #(
  parameter int N_CH    = 16,
  parameter int N_PIX   = 64,
  parameter int COEFF_W = 16,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 8
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [COEFF_W-1:0] bias_V_dout,
  input  logic               bias_V_empty_n,
  output logic               bias_V_read,
  input  logic [ACC_W-1:0]   input_V_dout,
  input  logic               input_V_empty_n,
  output logic               input_V_read,
  output logic [OUT_W-1:0]   output_V_din,
  input  logic               output_V_full_n,
  output logic               output_V_write
);

  localparam int CH_W  = (N_CH  > 1) ? $clog2(N_CH)  : 1;
  localparam int PIX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIX - 1);
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

  state_t                    state;
  logic [CH_W-1:0]           ld_cnt;
  logic [CH_W-1:0]           ch_cnt;
  logic [PIX_W-1:0]          pix_cnt;
  logic signed [COEFF_W-1:0] bank [N_CH];
  logic                      vld_p1;
  logic signed [OUT_W-1:0]   dout_p1;
  logic                      pop_bias;
  logic                      pop_in;
  logic                      push_out;

  // One extra bit of headroom makes the add exact for any operand pair.
  function automatic logic signed [ACC_W:0] add_bias(
    input logic signed [ACC_W-1:0]   acc,
    input logic signed [COEFF_W-1:0] b
  );
    logic signed [ACC_W:0] acc_x;
    logic signed [ACC_W:0] b_x;
    acc_x = {acc[ACC_W-1], acc};
    b_x   = {{(ACC_W + 1 - COEFF_W){b[COEFF_W-1]}}, b};
    return acc_x + b_x;
  endfunction

  function automatic logic signed [OUT_W-1:0] shift_sat(
    input logic signed [ACC_W:0] sum
  );
    logic signed [ACC_W:0] res;
    res = sum >>> SHIFT;
    if (res > SAT_MAX)
      return {1'b0, {(OUT_W - 1){1'b1}}};
    else if (res < SAT_MIN)
      return {1'b1, {(OUT_W - 1){1'b0}}};
    else
      return res[OUT_W-1:0];
  endfunction

  assign pop_bias       = ap_rst_n && (state == LOAD) && bias_V_empty_n;
  assign pop_in         = ap_rst_n && (state == RUN) && input_V_empty_n &&
                          (!vld_p1 || output_V_full_n);
  assign push_out       = ap_rst_n && vld_p1 && output_V_full_n;
  assign bias_V_read    = pop_bias;
  assign input_V_read   = pop_in;
  assign output_V_write = push_out;
  assign output_V_din   = dout_p1;

  // p0 -> p1: bias add, rescale and saturate into the output register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state   <= LOAD;
      ld_cnt  <= '0;
      ch_cnt  <= '0;
      pix_cnt <= '0;
      vld_p1  <= 1'b0;
      dout_p1 <= '0;
      for (int i = 0; i < N_CH; i++) bank[i] <= '0;
    end else begin
      if (pop_bias) begin
        bank[ld_cnt] <= bias_V_dout;
        if (ld_cnt == CH_LAST) begin
          ld_cnt <= '0;
          state  <= RUN;
        end else begin
          ld_cnt <= ld_cnt + CH_W'(1);
        end
      end

      if (pop_in) begin
        dout_p1 <= shift_sat(add_bias(input_V_dout, bank[ch_cnt]));
        vld_p1  <= 1'b1;
        if (ch_cnt == CH_LAST) begin
          ch_cnt <= '0;
          if (pix_cnt == PIX_LAST) begin
            pix_cnt <= '0;
            state   <= DRAIN;
          end else begin
            pix_cnt <= pix_cnt + PIX_W'(1);
          end
        end else begin
          ch_cnt <= ch_cnt + CH_W'(1);
        end
      end else if (push_out) begin
        vld_p1 <= 1'b0;
      end

      // The last word of the frame must leave before the next bias set lands.
      if (state == DRAIN && (!vld_p1 || push_out)) begin
        state   <= LOAD;
        pix_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bias_add_3.sv
// Scoreboard bench for bias_add_3: FIFO models feed random traffic, a model
// predicts each output word, and a monitor checks words as they are pushed.
module tb_bias_add_3;

  localparam int N_CH    = 16;
  localparam int N_PIX   = 64;
  localparam int COEFF_W = 16;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 16;
  localparam int SHIFT   = 8;
  localparam int FRAME   = N_PIX * N_CH;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic [COEFF_W-1:0] bias_V_dout = '0;
  logic               bias_V_empty_n = 1'b0;
  logic               bias_V_read;
  logic [ACC_W-1:0]   input_V_dout = '0;
  logic               input_V_empty_n = 1'b0;
  logic               input_V_read;
  logic [OUT_W-1:0]   output_V_din;
  logic               output_V_full_n = 1'b1;
  logic               output_V_write;

  bias_add_3 #(
    .N_CH(N_CH), .N_PIX(N_PIX), .COEFF_W(COEFF_W),
    .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .bias_V_dout(bias_V_dout),
    .bias_V_empty_n(bias_V_empty_n),
    .bias_V_read(bias_V_read),
    .input_V_dout(input_V_dout),
    .input_V_empty_n(input_V_empty_n),
    .input_V_read(input_V_read),
    .output_V_din(output_V_din),
    .output_V_full_n(output_V_full_n),
    .output_V_write(output_V_write)
  );

  always #5 ap_clk = ~ap_clk;

  logic [COEFF_W-1:0] bias_q[$];
  logic [ACC_W-1:0]   in_q[$];
  logic [OUT_W-1:0]   exp_q[$];
  logic [COEFF_W-1:0] frame_bias [2][N_CH];
  int errors = 0;
  int checks = 0;
  int bias_pops = 0;
  int in_pops = 0;
  int in_pushed = 0;
  int full_mode = 0;
  int cyc = 0;
  logic [3:0] full_pat = 4'b1001;

  // Reference: exact sum, floor division by 2^SHIFT, clamp to the output range.
  function automatic logic [OUT_W-1:0] model(input logic [ACC_W-1:0] acc,
                                              input logic [COEFF_W-1:0] b);
    longint s;
    longint d;
    longint q;
    longint lo;
    longint hi;
    s  = longint'($signed(acc)) + longint'($signed(b));
    d  = longint'(1) << SHIFT;
    q  = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q[OUT_W-1:0];
  endfunction

  function automatic logic [ACC_W-1:0] rnd_acc();
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
      default: return 32'($urandom_range(0, 32'h0001_FFFF)) - 32'h0001_0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_bias(input int f, input int ch, input logic [COEFF_W-1:0] v);
    frame_bias[f][ch] = v;
    bias_q.push_back(v);
  endtask

  task automatic push_in(input logic [ACC_W-1:0] acc);
    int f;
    int ch;
    f  = in_pushed / FRAME;
    ch = in_pushed % N_CH;
    exp_q.push_back(model(acc, frame_bias[f][ch]));
    in_q.push_back(acc);
    in_pushed++;
  endtask

  task automatic drive();
    bias_V_empty_n  = (bias_q.size() != 0);
    bias_V_dout     = (bias_q.size() != 0) ? bias_q[0] : '0;
    input_V_empty_n = (in_q.size() != 0);
    input_V_dout    = (in_q.size() != 0) ? in_q[0] : '0;
  endtask

  // Pops are decided by the strobes before the edge and applied just after it.
  task automatic tick();
    logic pb;
    logic pi;
    logic [ACC_W-1:0] d_in;
    logic [COEFF_W-1:0] d_b;
    @(negedge ap_clk);
    pb = bias_V_read && bias_V_empty_n;
    pi = input_V_read && input_V_empty_n;
    @(posedge ap_clk);
    #1;
    cyc++;
    if (pb) begin
      d_b = bias_q.pop_front();
      bias_pops++;
    end
    if (pi) begin
      d_in = in_q.pop_front();
      in_pops++;
      if (in_pops == FRAME + 1) check("reload_before_frame2", 32'(bias_pops), 32'(2 * N_CH));
    end
    case (full_mode)
      0:       output_V_full_n = 1'b1;
      1:       output_V_full_n = full_pat[cyc % 4];
      default: output_V_full_n = 1'($urandom_range(0, 1));
    endcase
    drive();
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || in_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d words outstanding, %0d inputs unread", exp_q.size(), in_q.size());
    end
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    #1;
    check("rst_write", 32'(output_V_write), 32'd0);
    check("rst_bias_read", 32'(bias_V_read), 32'd0);
    check("rst_input_read", 32'(input_V_read), 32'd0);
    check("rst_din", 32'(output_V_din), 32'd0);
    bias_q.delete();
    in_q.delete();
    exp_q.delete();
    bias_pops = 0;
    in_pops = 0;
    in_pushed = 0;
    drive();
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
  endtask

  // Monitor: compares every pushed word and the hold-under-back-pressure rule.
  initial begin
    logic prev_rst;
    logic prev_full;
    logic prev_pop;
    logic [OUT_W-1:0] prev_din;
    logic [OUT_W-1:0] exp;
    prev_rst = 1'b0;
    prev_full = 1'b1;
    prev_pop = 1'b0;
    prev_din = '0;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n && output_V_write) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %0h expected no word", output_V_din);
        end else begin
          exp = exp_q.pop_front();
          check("out_word", 32'(output_V_din), 32'(exp));
        end
      end
      if (ap_rst_n && prev_rst && !prev_full && !prev_pop)
        check("din_hold", 32'(output_V_din), 32'(prev_din));
      prev_rst  = ap_rst_n;
      prev_full = output_V_full_n;
      prev_pop  = input_V_read && input_V_empty_n;
      prev_din  = output_V_din;
    end
  end

  initial begin
    int n;
    // Biases 0..15, inputs 256 everywhere: every result is 1.
    for (int ch = 0; ch < N_CH; ch++) set_bias(0, ch, COEFF_W'(ch));
    for (int ch = 0; ch < N_CH; ch++) push_in(32'd256);
    drive();
    #12;
    check("rst_bias_read_hold", 32'(bias_V_read), 32'd0);
    check("rst_input_read_hold", 32'(input_V_read), 32'd0);
    check("rst_write_hold", 32'(output_V_write), 32'd0);
    check("rst_din_hold", 32'(output_V_din), 32'd0);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    run_idle(300);
    check("bias_pops_seg1", 32'(bias_pops), 32'(N_CH));

    // Rounding, sign extension and both saturation rails, then random traffic.
    do_reset();
    set_bias(0, 0, 16'hFFFF);
    set_bias(0, 1, 16'h7FFF);
    set_bias(0, 2, 16'h8000);
    for (int ch = 3; ch < N_CH; ch++) set_bias(0, ch, COEFF_W'($urandom));
    push_in(32'h0000_0000);
    push_in(32'h7FFF_FFFF);
    push_in(32'h8000_0000);
    for (int i = 3; i < 4 * N_CH; i++) push_in(rnd_acc());
    full_mode = 1;
    drive();
    run_idle(1000);

    // Reset with a word pending mid-pixel, then a clean reload.
    full_mode = 0;
    do_reset();
    for (int ch = 0; ch < N_CH; ch++) set_bias(0, ch, COEFF_W'($urandom));
    for (int i = 0; i < 20; i++) push_in(rnd_acc());
    drive();
    n = 0;
    while (in_pops < 6 && n < 200) begin
      tick();
      n++;
    end
    check("mid_frame_pops", 32'(in_pops), 32'd6);
    do_reset();
    for (int ch = 0; ch < N_CH; ch++) set_bias(0, ch, COEFF_W'($urandom));
    for (int i = 0; i < N_CH; i++) push_in(rnd_acc());
    drive();
    run_idle(300);
    check("bias_pops_after_reset", 32'(bias_pops), 32'(N_CH));

    // Full frame, drain, second bias set, start of frame 2 under back-pressure.
    full_mode = 1;
    do_reset();
    for (int ch = 0; ch < N_CH; ch++) set_bias(0, ch, COEFF_W'($urandom));
    for (int ch = 0; ch < N_CH; ch++) set_bias(1, ch, COEFF_W'($urandom));
    for (int i = 0; i < FRAME + 2 * N_CH; i++) push_in(rnd_acc());
    drive();
    run_idle(6000);
    check("in_pops_two_frames", 32'(in_pops), 32'(FRAME + 2 * N_CH));
    full_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
